// File: rtl/color_pkg.sv
// Shared types for the dice turn sequencer: detector colors and FSM states.
package color_pkg;

  typedef enum logic [1:0] {
    ColNone  = 2'b00,
    ColRed   = 2'b01,
    ColGreen = 2'b10,
    ColBlue  = 2'b11
  } color_t;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StWaitClear = 3'd1,
    StWaitDice  = 3'd2,
    StConfirm   = 3'd3,
    StPresent   = 3'd4
  } seq_state_t;

  localparam int unsigned FrameCntW = 16;
  localparam int unsigned MatchCntW = 3;

endpackage

// File: rtl/frame_timeout_counter.sv
// Saturating per-turn frame counter; expired is high once count has reached limit.
module frame_timeout_counter
  import color_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 tick,
  input  logic [FrameCntW-1:0] limit,
  output logic [FrameCntW-1:0] count,
  output logic                 expired
);

  logic [FrameCntW-1:0] count_q, count_d;

  // Next count: clear wins, otherwise count enabled ticks and stick at all-ones.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && tick && (count_q != {FrameCntW{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign expired = (count_q >= limit);

endmodule

// File: rtl/dice_turn_sequencer.sv
// Runs one dice-reading turn: wait for an empty tray, confirm a stable color over
// several detector results (or forfeit on frame timeout), then hold the result
// until the consumer takes it and hand the turn to the other player.
module dice_turn_sequencer
  import color_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_FRAMES = 16'd600,
  parameter int unsigned CONFIRM_COUNT  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll_req,
  input  logic       abort,
  input  logic       new_game,
  input  logic       frame_tick,
  input  logic [1:0] stable_color,
  input  logic       result_ready,
  input  logic       current_state_white,
  input  logic       res_ready,
  output logic       res_valid,
  output logic [1:0] res_color,
  output logic       res_timeout,
  output logic       res_player,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam logic [MatchCntW-1:0] ConfirmCnt = MatchCntW'(CONFIRM_COUNT);

  seq_state_t            state_q, state_d;
  color_t                cand_q, cand_d;
  color_t                color_q, color_d;
  logic [MatchCntW-1:0]  match_q, match_d;
  logic                  player_q, player_d;
  logic                  timeout_q, timeout_d;

  logic [FrameCntW-1:0]  frame_count;
  logic                  frame_expired;
  logic                  cnt_clear;
  logic                  cnt_enable;
  logic                  timeout_hit;
  logic                  res_nonzero;
  logic                  accept;
  color_t                in_color;

  assign in_color    = color_t'(stable_color);
  assign res_nonzero = result_ready && (in_color != ColNone);
  assign cnt_enable  = (state_q == StWaitClear) || (state_q == StWaitDice) ||
                       (state_q == StConfirm);
  assign cnt_clear   = abort || new_game || ((state_q == StIdle) && roll_req);

  // This tick makes the count reach the limit (or it is already there).
  assign timeout_hit = cnt_enable && frame_tick &&
                       (frame_expired || (frame_count == TIMEOUT_FRAMES - 16'd1));

  // A result that completes the confirmation run this cycle.
  assign accept = res_nonzero &&
                  (((state_q == StWaitDice) && (ConfirmCnt == 3'd1)) ||
                   ((state_q == StConfirm) && (in_color == cand_q) &&
                    ((match_q + 3'd1) == ConfirmCnt)));

  frame_timeout_counter u_frame_timeout_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .tick    (frame_tick),
    .limit   (TIMEOUT_FRAMES),
    .count   (frame_count),
    .expired (frame_expired)
  );

  // Next-state logic: abort/new_game first, then accepted color over timeout.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    color_d   = color_q;
    match_d   = match_q;
    player_d  = player_q;
    timeout_d = timeout_q;

    if (new_game || abort) begin
      state_d = StIdle;
      match_d = '0;
      cand_d  = ColNone;
      if (new_game) player_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (roll_req) begin
            state_d = StWaitClear;
            match_d = '0;
            cand_d  = ColNone;
          end
        end
        StPresent: begin
          if (res_ready) begin
            state_d  = StIdle;
            player_d = ~player_q;
          end
        end
        StWaitClear, StWaitDice, StConfirm: begin
          if (accept) begin
            state_d   = StPresent;
            color_d   = in_color;
            timeout_d = 1'b0;
            match_d   = ConfirmCnt;
          end else if (timeout_hit) begin
            state_d   = StPresent;
            color_d   = ColNone;
            timeout_d = 1'b1;
          end else begin
            case (state_q)
              StWaitClear: begin
                if (frame_tick && current_state_white) state_d = StWaitDice;
              end
              StWaitDice: begin
                if (res_nonzero) begin
                  cand_d  = in_color;
                  match_d = 3'd1;
                  state_d = StConfirm;
                end
              end
              StConfirm: begin
                // A white frame means the dice left the tray: start over.
                if (frame_tick && current_state_white) begin
                  state_d = StWaitDice;
                  match_d = '0;
                end else if (res_nonzero) begin
                  if (in_color == cand_q) begin
                    match_d = match_q + 3'd1;
                  end else begin
                    cand_d  = in_color;
                    match_d = 3'd1;
                  end
                end
              end
              default: ;
            endcase
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cand_q    <= ColNone;
      color_q   <= ColNone;
      match_q   <= '0;
      player_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      color_q   <= color_d;
      match_q   <= match_d;
      player_q  <= player_d;
      timeout_q <= timeout_d;
    end
  end

  assign res_valid   = (state_q == StPresent);
  assign res_color   = color_q;
  assign res_timeout = timeout_q;
  assign res_player  = player_q;
  assign busy        = (state_q != StIdle);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_dice_turn_sequencer.sv
// Directed plus random checks of dice_turn_sequencer against a turn-level model.
module tb_dice_turn_sequencer;

  localparam logic [15:0] TF = 16'd4;
  localparam int CC = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       roll_req = 1'b0, abort = 1'b0, new_game = 1'b0, frame_tick = 1'b0;
  logic [1:0] stable_color = 2'b00;
  logic       result_ready = 1'b0, current_state_white = 1'b0, res_ready = 1'b0;
  logic       res_valid, res_timeout, res_player, busy;
  logic [1:0] res_color;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // Model of the turn: phase numbers are the documented state codes.
  int         m_phase;
  int         m_frames;
  int         m_streak;
  logic [1:0] m_cand;
  logic [1:0] m_color;
  bit         m_timeout;
  bit         m_player;

  always #5 clk = ~clk;

  dice_turn_sequencer #(
    .TIMEOUT_FRAMES (TF),
    .CONFIRM_COUNT  (CC)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .roll_req            (roll_req),
    .abort               (abort),
    .new_game            (new_game),
    .frame_tick          (frame_tick),
    .stable_color        (stable_color),
    .result_ready        (result_ready),
    .current_state_white (current_state_white),
    .res_ready           (res_ready),
    .res_valid           (res_valid),
    .res_color           (res_color),
    .res_timeout         (res_timeout),
    .res_player          (res_player),
    .busy                (busy),
    .state_dbg           (state_dbg)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_frames = 0; m_streak = 0;
    m_cand = 2'b00; m_color = 2'b00; m_timeout = 1'b0; m_player = 1'b0;
  endtask

  // One clock of the turn rules, using the inputs currently driven.
  task automatic model_step();
    int nf;
    bit expire, accept, got;
    got    = result_ready && (stable_color != 2'b00);
    nf     = m_frames;
    expire = 1'b0;
    if (new_game || abort) begin
      m_phase = 0; m_frames = 0; m_streak = 0;
      if (new_game) m_player = 1'b0;
    end else if (m_phase == 0) begin
      if (roll_req) begin m_phase = 1; m_frames = 0; m_streak = 0; end
    end else if (m_phase == 4) begin
      if (res_ready) begin m_phase = 0; m_player = ~m_player; end
    end else begin
      if (frame_tick) begin
        nf = (m_frames < 65535) ? m_frames + 1 : m_frames;
        expire = (nf >= int'(TF));
      end
      m_frames = nf;
      accept = got && ((m_phase == 2 && CC == 1) ||
                       (m_phase == 3 && stable_color == m_cand && m_streak + 1 == CC));
      if (accept) begin
        m_phase = 4; m_color = stable_color; m_timeout = 1'b0;
      end else if (expire) begin
        m_phase = 4; m_color = 2'b00; m_timeout = 1'b1;
      end else if (m_phase == 1) begin
        if (frame_tick && current_state_white) m_phase = 2;
      end else if (m_phase == 2) begin
        if (got) begin m_cand = stable_color; m_streak = 1; m_phase = 3; end
      end else begin
        if (frame_tick && current_state_white) begin
          m_phase = 2; m_streak = 0;
        end else if (got) begin
          if (stable_color == m_cand) m_streak++;
          else begin m_cand = stable_color; m_streak = 1; end
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("res_valid", res_valid, m_phase == 4);
    chk("busy", busy, m_phase != 0);
    chk("state_dbg", state_dbg, m_phase[2:0]);
    chk("res_player", res_player, m_player);
    if (m_phase == 4) begin
      chk("res_color", res_color, m_color);
      chk("res_timeout", res_timeout, m_timeout);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, res_valid, 1'b0);
    chk({tag, "_color"}, res_color, 2'b00);
    chk({tag, "_timeout"}, res_timeout, 1'b0);
    chk({tag, "_player"}, res_player, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_state"}, state_dbg, 3'd0);
  endtask

  task automatic cyc(input bit rr, input bit ft, input bit wh, input bit rdy,
                     input logic [1:0] col, input bit rrdy, input bit ab, input bit ng);
    roll_req = rr; frame_tick = ft; current_state_white = wh; result_ready = rdy;
    stable_color = col; res_ready = rrdy; abort = ab; new_game = ng;
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic roll();              cyc(1, 0, 0, 0, 2'b00, 0, 0, 0); endtask
  task automatic white();             cyc(0, 1, 1, 0, 2'b00, 0, 0, 0); endtask
  task automatic tick();              cyc(0, 1, 0, 0, 2'b00, 0, 0, 0); endtask
  task automatic res(input logic [1:0] c); cyc(0, 0, 0, 1, c, 0, 0, 0); endtask
  task automatic hs();                cyc(0, 0, 0, 0, 2'b00, 1, 0, 0); endtask
  task automatic hold();              cyc(0, 0, 0, 0, 2'b00, 0, 0, 0); endtask

  initial begin
    model_reset();
    #2;
    check_reset_values("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // Nominal turn for player 0, then backpressure for 10 cycles.
    roll(); white();
    res(2'b01); res(2'b01); res(2'b01);
    chk("nom_valid", res_valid, 1'b1);
    chk("nom_color", res_color, 2'b01);
    chk("nom_player", res_player, 1'b0);
    for (int i = 0; i < 10; i++) hold();
    chk("hold_color", res_color, 2'b01);
    hs();
    chk("hs_state", state_dbg, 3'd0);
    chk("hs_player", res_player, 1'b1);

    // Confirmation restarts on a different color.
    roll(); white();
    res(2'b01); res(2'b01); res(2'b10); res(2'b10);
    chk("restart_not_yet", res_valid, 1'b0);
    res(2'b10);
    chk("restart_color", res_color, 2'b10);
    hs();

    // Forfeit after the frame budget runs out.
    roll(); white(); tick(); tick(); tick(); tick();
    chk("to_timeout", res_timeout, 1'b1);
    chk("to_color", res_color, 2'b00);
    hs();
    chk("to_player", res_player, 1'b1);

    // Abort while presenting keeps the player.
    roll(); white(); res(2'b11); res(2'b11); res(2'b11);
    cyc(0, 0, 0, 0, 2'b00, 1, 1, 0);
    chk("abort_valid", res_valid, 1'b0);
    chk("abort_player", res_player, 1'b1);

    // Third match lands on the expiring tick: the color wins.
    roll(); white(); res(2'b01); res(2'b01); tick(); tick();
    cyc(0, 1, 0, 1, 2'b01, 0, 0, 0);
    chk("tie_timeout", res_timeout, 1'b0);
    chk("tie_color", res_color, 2'b01);
    hs();
    chk("tie_player", res_player, 1'b0);

    // new_game from player 1 clears the player.
    roll(); white(); res(2'b10); res(2'b10); res(2'b10); hs();
    roll(); cyc(0, 0, 0, 0, 2'b00, 0, 0, 1);
    chk("ng_player", res_player, 1'b0);

    // Ignored roll_req while busy, then async reset mid-CONFIRM as player 1.
    roll(); white(); res(2'b01); res(2'b01); res(2'b01); hs();
    roll(); cyc(1, 1, 1, 0, 2'b00, 0, 0, 0); res(2'b11);
    chk("pre_rst_state", state_dbg, 3'd3);
    #2 reset = 1'b1;
    #1;
    check_reset_values("async_rst");
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
          $urandom_range(0, 1) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
          $urandom_range(0, 59) == 0, $urandom_range(0, 119) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
